// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants and the width helper shared by the
// VGA timing generator files.
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;

  // Bits needed to hold 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int w;
    int v;
    w = 0;
    v = value - 1;
    while (v > 0) begin
      w++;
      v = v >> 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-enable input and the fetch/sync outputs of the VGA timing generator.
// fetchValid qualifies column/row; there is no back-pressure.
interface vga_timing_gen_if #(
  parameter int COL_W = 10,
  parameter int ROW_W = 9
);
  logic             clkDiv;
  logic             hSync;
  logic             vSync;
  logic             displayActive;
  logic             fetchValid;
  logic [COL_W-1:0] column;
  logic [ROW_W-1:0] row;
  logic             lineStart;
  logic             frameStart;

  modport master (
    input  clkDiv,
    output hSync, vSync, displayActive, fetchValid, column, row, lineStart, frameStart
  );

  modport slave (
    output clkDiv,
    input  hSync, vSync, displayActive, fetchValid, column, row, lineStart, frameStart
  );
endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis: a wrapping count plus active/sync decode, regions ordered
// active, front porch, sync, back porch from count 0.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FRONT  = DEF_H_FRONT,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BACK   = DEF_H_BACK,
  parameter bit POL    = 1'b0,
  localparam int TOTAL = ACTIVE + FRONT + SYNC + BACK,
  localparam int W     = clog2(TOTAL)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic         active,
  output logic         sync
);
  localparam int SYNC_START = ACTIVE + FRONT;
  localparam int SYNC_END   = SYNC_START + SYNC;

  logic [31:0] count_ext;
  logic        in_sync;

  // Region compares done at 32 bits so a sync region ending exactly at 2**W
  // cannot alias to zero.
  assign count_ext = 32'(count);
  assign wrap      = en && (count_ext == 32'(TOTAL - 1));
  assign active    = count_ext < 32'(ACTIVE);
  assign in_sync   = (count_ext >= 32'(SYNC_START)) && (count_ext < 32'(SYNC_END));
  assign sync      = in_sync ? POL : ~POL;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: fetch-side coordinates with strobes, and sync/active
// outputs delayed LEAD pixel slots so a fetch pipeline can run ahead.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FRONT  = DEF_H_FRONT,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BACK   = DEF_H_BACK,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FRONT  = DEF_V_FRONT,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int LEAD     = 0,
  parameter int COL_W    = 10,
  parameter int ROW_W    = 9
) (
  input logic              clk,
  input logic              rst,
  vga_timing_gen_if.master vga
);
  localparam int H_W = clog2(H_ACTIVE + H_FRONT + H_SYNC + H_BACK);
  localparam int V_W = clog2(V_ACTIVE + V_FRONT + V_SYNC + V_BACK);

  logic [H_W-1:0] h_count;
  logic [V_W-1:0] v_count;
  logic           h_wrap, h_active, h_sync;
  logic           v_wrap, v_active, v_sync;
  logic           raw_active;
  logic           hs_tail, vs_tail, da_tail;
  logic           frame_seen;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .POL(H_POL)
  ) u_h_axis (
    .clk(clk), .rst(rst), .en(vga.clkDiv),
    .count(h_count), .wrap(h_wrap), .active(h_active), .sync(h_sync)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .POL(V_POL)
  ) u_v_axis (
    .clk(clk), .rst(rst), .en(h_wrap),
    .count(v_count), .wrap(v_wrap), .active(v_active), .sync(v_sync)
  );

  assign raw_active = h_active && v_active;

  if (LEAD > 0) begin : g_lead
    logic [LEAD-1:0] hs_q, vs_q, da_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        hs_q <= {LEAD{~H_POL}};
        vs_q <= {LEAD{~V_POL}};
        da_q <= '0;
      end else if (vga.clkDiv) begin
        hs_q <= LEAD'({hs_q, h_sync});
        vs_q <= LEAD'({vs_q, v_sync});
        da_q <= LEAD'({da_q, raw_active});
      end
    end

    assign hs_tail = hs_q[LEAD-1];
    assign vs_tail = vs_q[LEAD-1];
    assign da_tail = da_q[LEAD-1];
  end else begin : g_no_lead
    assign hs_tail = h_sync;
    assign vs_tail = v_sync;
    assign da_tail = raw_active;
  end

  // frame_seen keeps frameStart quiet for the (0,0) slot right after reset;
  // it arms on the first full-frame wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga.hSync         <= ~H_POL;
      vga.vSync         <= ~V_POL;
      vga.displayActive <= 1'b0;
      vga.fetchValid    <= 1'b0;
      vga.column        <= '0;
      vga.row           <= '0;
      vga.lineStart     <= 1'b0;
      vga.frameStart    <= 1'b0;
      frame_seen        <= 1'b0;
    end else begin
      vga.lineStart  <= 1'b0;
      vga.frameStart <= 1'b0;
      if (vga.clkDiv) begin
        if (v_wrap) frame_seen <= 1'b1;
        vga.fetchValid    <= raw_active;
        vga.column        <= raw_active ? COL_W'(h_count) : '0;
        vga.row           <= raw_active ? ROW_W'(v_count) : '0;
        vga.lineStart     <= (h_count == '0);
        vga.frameStart    <= (h_count == '0) && (v_count == '0) && frame_seen;
        vga.hSync         <= hs_tail;
        vga.vSync         <= vs_tail;
        vga.displayActive <= da_tail;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised pixel-enable and reset stimulus on two small-timing generators
// (LEAD 0 and LEAD 3), checked against a slot-count arithmetic model.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk_div = 1'b0;
  always #10 clk = ~clk;

  vga_timing_gen_if #(.COL_W(10), .ROW_W(9)) bus_a ();
  vga_timing_gen_if #(.COL_W(10), .ROW_W(9)) bus_b ();
  assign bus_a.clkDiv = clk_div;
  assign bus_b.clkDiv = clk_div;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .H_POL(1'b1), .V_POL(1'b0), .LEAD(0), .COL_W(10), .ROW_W(9)
  ) u_dut_a (.clk(clk), .rst(rst), .vga(bus_a));

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .H_POL(1'b0), .V_POL(1'b1), .LEAD(3), .COL_W(10), .ROW_W(9)
  ) u_dut_b (.clk(clk), .rst(rst), .vga(bus_b));

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected outputs after k enabled edges since reset; {hs,vs,da,fv,col,row,ls,fs}.
  function automatic logic [24:0] model_vec(input int k, input bit en_last, input int lead,
                                             input bit hpol, input bit vpol);
    logic hs, vs, da, fv, ls, fs;
    logic [9:0] col;
    logic [8:0] row;
    int n, x, y, d, m, hx, hy;
    if (k == 0) return {~hpol, ~vpol, 1'b0, 1'b0, 10'd0, 9'd0, 1'b0, 1'b0};
    n  = (k - 1) % FT;
    x  = n % HT;
    y  = n / HT;
    fv = (x < HA) && (y < VA);
    col = fv ? 10'(x) : 10'd0;
    row = fv ? 9'(y) : 9'd0;
    d = k - 1 - lead;
    if (d < 0) begin
      hs = ~hpol; vs = ~vpol; da = 1'b0;
    end else begin
      m  = d % FT;
      hx = m % HT;
      hy = m / HT;
      hs = (hx >= HA + HF && hx < HA + HF + HS) ? hpol : ~hpol;
      vs = (hy >= VA + VF && hy < VA + VF + VS) ? vpol : ~vpol;
      da = (hx < HA) && (hy < VA);
    end
    ls = en_last && (x == 0);
    fs = en_last && (n == 0) && (k > 1);
    return {hs, vs, da, fv, col, row, ls, fs};
  endfunction

  // scoreboard
  int k = 0;
  bit en_last = 1'b0;
  logic [24:0] exp_a_q[$];
  logic [24:0] exp_b_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      k = 0;
      en_last = 1'b0;
    end else begin
      en_last = clk_div;
      if (clk_div) k++;
    end
    exp_a_q.delete();
    exp_b_q.delete();
    exp_a_q.push_back(model_vec(k, en_last, 0, 1'b1, 1'b0));
    exp_b_q.push_back(model_vec(k, en_last, 3, 1'b0, 1'b1));
  end

  task automatic compare_fields(input string p, input logic [24:0] got, input logic [24:0] exp);
    check({p, "_hsync"},  32'(got[24]),    32'(exp[24]));
    check({p, "_vsync"},  32'(got[23]),    32'(exp[23]));
    check({p, "_active"}, 32'(got[22]),    32'(exp[22]));
    check({p, "_fvalid"}, 32'(got[21]),    32'(exp[21]));
    check({p, "_column"}, 32'(got[20:11]), 32'(exp[20:11]));
    check({p, "_row"},    32'(got[10:2]),  32'(exp[10:2]));
    check({p, "_lstart"}, 32'(got[1]),     32'(exp[1]));
    check({p, "_fstart"}, 32'(got[0]),     32'(exp[0]));
  endtask

  function automatic logic [24:0] bus_a_vec();
    return {bus_a.hSync, bus_a.vSync, bus_a.displayActive, bus_a.fetchValid,
            bus_a.column, bus_a.row, bus_a.lineStart, bus_a.frameStart};
  endfunction

  function automatic logic [24:0] bus_b_vec();
    return {bus_b.hSync, bus_b.vSync, bus_b.displayActive, bus_b.fetchValid,
            bus_b.column, bus_b.row, bus_b.lineStart, bus_b.frameStart};
  endfunction

  always @(negedge clk) begin
    if (exp_a_q.size() != 1 || exp_b_q.size() != 1) begin
      check("queue_depth", 32'(exp_a_q.size() + exp_b_q.size()), 32'd2);
    end else begin
      compare_fields("a", bus_a_vec(), exp_a_q.pop_front());
      compare_fields("b", bus_b_vec(), exp_b_q.pop_front());
    end
  end

  // driver tasks
  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1;
    compare_fields("a_async_rst", bus_a_vec(), model_vec(0, 1'b0, 0, 1'b1, 1'b0));
    compare_fields("b_async_rst", bus_b_vec(), model_vec(0, 1'b0, 3, 1'b0, 1'b1));
    #4 rst = 1'b0;
  endtask

  task automatic run_toggle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      clk_div = ~clk_div;
    end
  endtask

  task automatic run_random(input int cycles, input int ones_weight, input int rst_odds);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      clk_div = ($urandom_range(0, ones_weight) != 0);
      if (rst_odds > 0 && $urandom_range(0, rst_odds - 1) == 0) pulse_reset();
    end
  endtask

  initial begin
    rst = 1'b1;
    clk_div = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    run_toggle(2 * FT * 2 + 37);
    @(negedge clk);
    clk_div = 1'b0;
    pulse_reset();
    run_random(1500, 3, 0);
    @(negedge clk);
    clk_div = 1'b0;
    repeat (1000) @(negedge clk);
    run_random(3000, 1, 300);
    run_random(400, 1000000, 0);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
